// File: rtl/wb_mst_pkg.sv
// Shared types and constants for the Wishbone command master.
// Command entries, FSM states and bus widths live here.
package wb_mst_pkg;

  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned SEL_W          = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 16;

  localparam logic [SEL_W-1:0] WB_SEL_BYTE = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // One queued command: {we, addr, wdata}
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wb_cmd_t;

  localparam int unsigned CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command queue: power-of-two deep, pointers wrap naturally.
// full/empty are registered alongside the occupancy count.
module wb_cmd_fifo
  import wb_mst_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_cmd_t din,
  input  logic    pop,
  output wb_cmd_t head_c,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointers, occupancy and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Queues register commands and replays them one at a time as Wishbone
// classic cycles, returning read data or a timeout flag per command.
module wb_cmd_master
  import wb_mst_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] wb_addr_i,
  output logic [DATA_W-1:0] wb_dat_i,
  output logic [SEL_W-1:0]  wb_sel_i,
  output logic              wb_we_i,
  output logic              wb_stb_i,
  output logic              wb_cyc_i,
  input  logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack_o,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  wb_state_e         state_q;
  wb_state_e         state_d;
  wb_cmd_t           cmd_in;
  wb_cmd_t           head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dat_d;
  logic [SEL_W-1:0]  sel_d;
  logic              we_d;
  logic              stb_d;
  logic              cyc_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

  assign cmd_in    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (push),
    .din    (cmd_in),
    .pop    (pop),
    .head_c (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Next-state and next-output logic; everything holds unless changed
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    tmo_d       = tmo_cnt;
    addr_d      = wb_addr_i;
    dat_d       = wb_dat_i;
    sel_d       = wb_sel_i;
    we_d        = wb_we_i;
    stb_d       = wb_stb_i;
    cyc_d       = wb_cyc_i;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          dat_d   = head.wdata;
          we_d    = head.we;
          sel_d   = WB_SEL_BYTE;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack wins over a timeout landing on the same edge
        if (wb_ack_o || (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
          rsp_rdata_d = (wb_ack_o && !wb_we_i) ? wb_dat_o : '0;
          rsp_err_d   = !wb_ack_o;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        we_d        = 1'b0;
        sel_d       = '0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmo_cnt   <= '0;
      wb_addr_i <= '0;
      wb_dat_i  <= '0;
      wb_sel_i  <= '0;
      wb_we_i   <= 1'b0;
      wb_stb_i  <= 1'b0;
      wb_cyc_i  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt   <= tmo_d;
      wb_addr_i <= addr_d;
      wb_dat_i  <= dat_d;
      wb_sel_i  <= sel_d;
      wb_we_i   <= we_d;
      wb_stb_i  <= stb_d;
      wb_cyc_i  <= cyc_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small Wishbone slave model
// whose ack delay and read data are set per test.
module tb_wb_cmd_master;
  import wb_mst_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [SEL_W-1:0]  wb_sel_i;
  logic              wb_we_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic [DATA_W-1:0] wb_dat_o = '0;
  logic              wb_ack_o = 1'b0;
  logic              busy;

  int n_vec = 0;
  int n_bad = 0;

  // Slave model controls and observations
  int                ack_at     = 0;
  logic              stray_ack  = 1'b0;
  logic [DATA_W-1:0] slave_base = '0;
  int                bus_cnt    = 0;
  int                last_len   = 0;
  logic [ADDR_W-1:0] seen_addr  = '0;
  logic [DATA_W-1:0] seen_dat   = '0;
  logic              seen_we    = 1'b0;
  logic [SEL_W-1:0]  seen_sel   = '0;
  logic              unstable   = 1'b0;

  always #5 clk = ~clk;

  wb_cmd_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr_i (wb_addr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .busy      (busy)
  );

  // Slave: acks in the ack_at-th stb cycle (0 = never), records cycle length
  always @(negedge clk) begin
    if (wb_cyc_i && wb_stb_i) begin
      bus_cnt <= bus_cnt + 1;
      if (bus_cnt == 0) begin
        seen_addr <= wb_addr_i;
        seen_dat  <= wb_dat_i;
        seen_we   <= wb_we_i;
        seen_sel  <= wb_sel_i;
      end else if (seen_addr !== wb_addr_i || seen_dat !== wb_dat_i ||
                   seen_we !== wb_we_i || seen_sel !== wb_sel_i) begin
        unstable <= 1'b1;
      end
      wb_ack_o <= (ack_at != 0) && (bus_cnt + 1 == ack_at);
    end else begin
      if (bus_cnt != 0) last_len <= bus_cnt;
      bus_cnt  <= 0;
      wb_ack_o <= stray_ack;
    end
    wb_dat_o <= slave_base ^ {5'b0, wb_addr_i};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk); #1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    check("push_rdy", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, optionally hold it, check, then consume it
  task automatic wait_rsp(input string tag, input logic [DATA_W-1:0] exp_rdata,
                          input logic exp_err, input int exp_len, input int hold);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!rsp_valid && k < 200);
    repeat (hold) begin
      @(negedge clk); #1;
    end
    check({tag, "_vld"},   32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    check({tag, "_err"},   32'(rsp_err),   32'(exp_err));
    check({tag, "_len"},   32'(last_len),  32'(exp_len));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rel"},   32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #20;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    check("rst_cyc",   32'(wb_cyc_i),  32'd0);
    check("rst_stb",   32'(wb_stb_i),  32'd0);
    check("rst_we",    32'(wb_we_i),   32'd0);
    check("rst_sel",   32'(wb_sel_i),  32'd0);
    check("rst_addr",  32'(wb_addr_i), 32'd0);
    check("rst_dat",   32'(wb_dat_i),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Write, ack in the second stb cycle; slave data must not leak into rdata
    ack_at = 2; slave_base = 8'hFF;
    push(1'b1, 3'd3, 8'h83);
    check("wr_cyc_e0", 32'(wb_cyc_i), 32'd0);
    check("wr_busy",   32'(busy),     32'd1);
    @(posedge clk); #1;
    check("wr_cyc_e1", 32'(wb_cyc_i), 32'd1);
    check("wr_stb_e1", 32'(wb_stb_i), 32'd1);
    wait_rsp("wr", 8'h00, 1'b0, 2, 0);
    check("wr_addr", 32'(seen_addr), 32'd3);
    check("wr_dat",  32'(seen_dat),  32'h83);
    check("wr_we",   32'(seen_we),   32'd1);
    check("wr_sel",  32'(seen_sel),  32'd1);
    check("wr_cyc_after", 32'(wb_cyc_i), 32'd0);
    check("wr_we_after",  32'(wb_we_i),  32'd0);
    check("wr_sel_after", 32'(wb_sel_i), 32'd0);

    // Read, ack in the fourth stb cycle: 0x65 ^ 5 = 0x60
    ack_at = 4; slave_base = 8'h65;
    push(1'b0, 3'd5, 8'h00);
    wait_rsp("rd", 8'h60, 1'b0, 4, 0);
    check("rd_addr", 32'(seen_addr), 32'd5);
    check("rd_we",   32'(seen_we),   32'd0);

    // Timeout with ack held high whenever no cycle is open
    ack_at = 0; slave_base = 8'h11; stray_ack = 1'b1;
    push(1'b0, 3'd2, 8'h00);
    wait_rsp("tmo", 8'h00, 1'b1, 16, 3);
    repeat (3) @(negedge clk);
    #1;
    check("tmo_late_vld",  32'(rsp_valid), 32'd0);
    check("tmo_late_busy", 32'(busy),      32'd0);
    check("tmo_late_cyc",  32'(wb_cyc_i),  32'd0);
    stray_ack = 1'b0;

    // Ack on the 16th stb cycle beats the timeout: 0x3C ^ 7 = 0x3B
    ack_at = 16; slave_base = 8'h3C;
    push(1'b0, 3'd7, 8'h00);
    wait_rsp("ack16", 8'h3B, 1'b0, 16, 0);

    // Ack one cycle too late is a timeout
    ack_at = 17;
    push(1'b0, 3'd7, 8'h00);
    wait_rsp("ack17", 8'h00, 1'b1, 16, 0);

    // Backpressure: five reads with rsp_ready low, one in flight plus four queued
    ack_at = 1; slave_base = 8'hA0;
    for (int i = 1; i <= 5; i++) push(1'b0, 3'(i), 8'h00);
    check("bp_full", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd6;
    repeat (3) @(negedge clk);
    #1;
    check("bp_still_full", 32'(cmd_ready), 32'd0);
    check("bp_busy",       32'(busy),      32'd1);
    cmd_valid = 1'b0;
    wait_rsp("bp1", 8'hA1, 1'b0, 1, 2);
    wait_rsp("bp2", 8'hA2, 1'b0, 1, 0);
    wait_rsp("bp3", 8'hA3, 1'b0, 1, 0);
    wait_rsp("bp4", 8'hA4, 1'b0, 1, 0);
    wait_rsp("bp5", 8'hA5, 1'b0, 1, 0);
    repeat (3) @(negedge clk);
    #1;
    check("bp_drained", 32'(busy), 32'd0);

    // Reset mid-cycle with a second command queued
    ack_at = 0; slave_base = 8'h55;
    push(1'b0, 3'd4, 8'h00);
    push(1'b1, 3'd6, 8'h99);
    repeat (3) @(negedge clk);
    #1;
    check("rb_cyc_pre", 32'(wb_cyc_i), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rb_cyc",   32'(wb_cyc_i),  32'd0);
    check("rb_stb",   32'(wb_stb_i),  32'd0);
    check("rb_busy",  32'(busy),      32'd0);
    check("rb_ready", 32'(cmd_ready), 32'd1);
    check("rb_valid", 32'(rsp_valid), 32'd0);

    // Command presented as reset releases is taken on the first edge
    ack_at = 2;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 3'd1; cmd_wdata = 8'h42;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("post_busy", 32'(busy), 32'd1);
    wait_rsp("post", 8'h00, 1'b0, 2, 0);
    check("post_addr", 32'(seen_addr), 32'd1);
    check("post_dat",  32'(seen_dat),  32'h42);
    check("post_we",   32'(seen_we),   32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("post_no_rsp",  32'(rsp_valid), 32'd0);
    check("post_idle",    32'(busy),      32'd0);
    check("bus_stable",   32'(unstable),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles waiting for wb_ack_o.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-007 SHALL have port cmd_we  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  3  UART register address.
REQ-009 SHALL have port cmd_wdata  input  8  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_rdata  output  8  read data (0 for writes and timeouts).
REQ-013 SHALL have port rsp_err  output  1  transaction timed out.
REQ-014 SHALL have ports wb_addr_i out 3, wb_dat_i out 8, wb_sel_i out 4, wb_we_i out 1, wb_stb_i out 1, wb_cyc_i out 1  Wishbone master outputs, named to connect 1:1 to the UART slave.
REQ-015 SHALL have ports wb_dat_o in 8, wb_ack_o in 1  Wishbone slave returns.
REQ-016 SHALL have port busy  output  1  FSM not IDLE or FIFO not empty.

Function
REQ-017 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = !fifo_full, no same-cycle bypass when full.
REQ-018 SHALL use FSM states IDLE, BUS, RESP.
REQ-019 IDLE: when FIFO non-empty, pop head, register addr/data/we onto Wishbone outputs, go BUS; wb_cyc_i/wb_stb_i high from next cycle.
REQ-020 Command pushed into empty FIFO while IDLE SHALL see wb_cyc_i high 2 cycles after the accepting edge.
REQ-021 BUS: wb_cyc_i=wb_stb_i=1, wb_sel_i=4'b0001, addr/data/we stable for whole cycle.
REQ-022 BUS: on edge with wb_ack_o=1, capture wb_dat_o (read) or 0 (write) into rsp_rdata, rsp_err=0, drop cyc/stb next cycle, go RESP.
REQ-023 BUS: wait counter counts BUS cycles; when it reaches TIMEOUT with no ack, rsp_err=1, rsp_rdata=0, drop cyc/stb, go RESP.
REQ-024 Ack arriving on the same edge as timeout SHALL count as ack (rsp_err=0).
REQ-025 wb_ack_o outside BUS SHALL be ignored.
REQ-026 RESP: rsp_valid=1, rsp_* held stable until edge with rsp_ready=1, then IDLE; new pop no earlier than next IDLE cycle.
REQ-027 Outside BUS: wb_cyc_i=wb_stb_i=wb_we_i=0, wb_sel_i=0; addr/data may hold last value.
REQ-028 Commands SHALL complete strictly in acceptance order; one outstanding Wishbone cycle max.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-030 rst low SHALL immediately force IDLE, FIFO empty, counter 0, all outputs 0 except cmd_ready=1.
REQ-031 Reset mid-BUS SHALL drop wb_cyc_i/wb_stb_i asynchronously; in-flight and queued commands discarded, no response.
REQ-032 First command accepted on first rising edge after rst deasserts.

Structure
REQ-033 Package wb_mst_pkg SHALL hold state enum (IDLE/BUS/RESP), WB_SEL_BYTE=4'b0001, widths ADDR_W=3, DATA_W=8, default FIFO_DEPTH and TIMEOUT.
REQ-034 Command storage SHALL be sub-module wb_cmd_fifo (12-bit entries {we,addr,wdata}, push/pop/full/empty).

Verification
REQ-035 Write: cmd {we=1,addr=3,wdata=0x83}, slave acks 1 cycle after stb -> wb_addr_i=3, wb_dat_i=0x83, wb_we_i=1; rsp_valid, rsp_err=0, rsp_rdata=0.
REQ-036 Read: cmd {we=0,addr=5}, slave returns 0x60 with ack after 3 cycles -> rsp_rdata=0x60, rsp_err=0, cyc held exactly 4 cycles.
REQ-037 Timeout: slave never acks, TIMEOUT=16 -> cyc high 16 cycles, then rsp_err=1, rsp_rdata=0; late ack ignored.
REQ-038 Backpressure: push 5 commands with rsp_ready=0 -> cmd_ready low after 4th accepted entry (head popped into BUS), responses in order once rsp_ready=1.
REQ-039 Reset mid-BUS: assert rst during read -> cyc/stb low same cycle without clock, no rsp_valid, busy=0, cmd_ready=1.
REQ-040 Ack on timeout edge: ack at 16th BUS cycle -> rsp_err=0, data captured.
